// File: rtl/pcd8544_spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcd8544_spi_rx: PCD8544 (Nokia 5110) serial-link receiver and decoder.     |
// | Optional macro RX_VOP_EN implements the vop/bias/tc registers.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pcd8544_spi_rx #(
    parameter int COLS        = 84,
    parameter int ROWS        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       sce,
    input  logic       dc,
    input  logic       lcd_rst,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic [1:0] disp_mode,
    output logic       pwr_down,
    output logic       vaddr,
    output logic       frame_done,
    output logic       err_frame,
    output logic [6:0] vop,
    output logic [2:0] bias,
    output logic [1:0] tc
);
    localparam int         c_SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int         c_XW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int         c_YW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Stage order {lcd_rst, dc, sce, mosi, sclk}; sce idles high (deselected).
    localparam logic [4:0] c_SYNC_RST = 5'b00100;

    logic [c_SYNC_N-1:0][4:0] r_sync;
    logic                     r_sclk_prev;
    logic w_sclk_s, w_mosi_s, w_sce_s, w_dc_s, w_lrst_s;
    logic w_rst, w_edge;
    logic [7:0] w_byte;
    logic [8:0] w_addr;

    logic [2:0]      r_bitcnt;
    logic [6:0]      r_shift;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic            r_h, r_v, r_pd;
    logic [1:0]      r_disp;
    logic            r_wr_en, r_cmd_valid, r_frame_done, r_err_frame;
    logic [8:0]      r_wr_addr;
    logic [7:0]      r_wr_data, r_cmd_byte;

    always_ff @(posedge clock) begin
        if (!Reset) begin
            r_sync      <= {c_SYNC_N{c_SYNC_RST}};
            r_sclk_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[c_SYNC_N-2:0], {lcd_rst, dc, sce, mosi, sclk}};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign {w_lrst_s, w_dc_s, w_sce_s, w_mosi_s, w_sclk_s} = r_sync[c_SYNC_N-1];
    assign w_rst  = !Reset || !w_lrst_s;
    assign w_edge = w_sclk_s && !r_sclk_prev;
    assign w_byte = {r_shift, w_mosi_s};
    assign w_addr = 9'(r_y) * 9'(COLS) + 9'(r_x);

`ifdef RX_VOP_EN
    logic [6:0] r_vop;
    logic [2:0] r_bias;
    logic [1:0] r_tc;
`endif

    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_bitcnt     <= 3'd0;
            r_shift      <= 7'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_h          <= 1'b0;
            r_v          <= 1'b0;
            r_pd         <= 1'b1;
            r_disp       <= 2'b00;
            r_wr_en      <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_frame  <= 1'b0;
            r_wr_addr    <= 9'd0;
            r_wr_data    <= 8'd0;
            r_cmd_byte   <= 8'd0;
`ifdef RX_VOP_EN
            r_vop        <= 7'd0;
            r_bias       <= 3'd0;
            r_tc         <= 2'd0;
`endif
        end else begin
            r_wr_en      <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_frame  <= 1'b0;
            if (w_sce_s) begin
                // Deselect aborts any partial byte.
                r_bitcnt <= 3'd0;
                if (r_bitcnt != 3'd0)
                    r_err_frame <= 1'b1;
            end else if (w_edge) begin
                r_shift  <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    if (w_dc_s) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_data <= w_byte;
                        if (!r_v) begin
                            if (r_x == c_XW'(COLS - 1)) begin
                                r_x <= '0;
                                if (r_y == c_YW'(ROWS - 1)) begin
                                    r_y          <= '0;
                                    r_frame_done <= 1'b1;
                                end else begin
                                    r_y <= r_y + 1'b1;
                                end
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end else begin
                            if (r_y == c_YW'(ROWS - 1)) begin
                                r_y <= '0;
                                if (r_x == c_XW'(COLS - 1)) begin
                                    r_x          <= '0;
                                    r_frame_done <= 1'b1;
                                end else begin
                                    r_x <= r_x + 1'b1;
                                end
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end
                    end else begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_byte  <= w_byte;
                        if (w_byte[7:3] == 5'b00100) begin
                            {r_pd, r_v, r_h} <= w_byte[2:0];
                        end else if (!r_h) begin
                            if (w_byte[7:3] == 5'b00001) begin
                                r_disp <= {w_byte[2], w_byte[0]};
                            end else if (w_byte[7:3] == 5'b01000) begin
                                if (int'(w_byte[2:0]) < ROWS)
                                    r_y <= c_YW'(w_byte[2:0]);
                            end else if (w_byte[7]) begin
                                if (int'(w_byte[6:0]) < COLS)
                                    r_x <= c_XW'(w_byte[6:0]);
                            end
                        end
`ifdef RX_VOP_EN
                        else begin
                            if (w_byte[7:2] == 6'b000001)
                                r_tc <= w_byte[1:0];
                            else if (w_byte[7:3] == 5'b00010)
                                r_bias <= w_byte[2:0];
                            else if (w_byte[7])
                                r_vop <= w_byte[6:0];
                        end
`endif
                    end
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_byte   = r_cmd_byte;
    assign disp_mode  = r_disp;
    assign pwr_down   = r_pd;
    assign vaddr      = r_v;
    assign frame_done = r_frame_done;
    assign err_frame  = r_err_frame;
`ifdef RX_VOP_EN
    assign vop        = r_vop;
    assign bias       = r_bias;
    assign tc         = r_tc;
`else
    assign vop        = 7'd0;
    assign bias       = 3'd0;
    assign tc         = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcd8544_spi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pcd8544_spi_rx: randomized bench for pcd8544_spi_rx with a reference    |
// | model of the display pointer and register state.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pcd8544_spi_rx;
    localparam int c_COLS = 84;
    localparam int c_ROWS = 6;

    logic       clock = 1'b0;
    logic       Reset, sclk, mosi, sce, dc, lcd_rst;
    logic       wr_en, cmd_valid, pwr_down, vaddr, frame_done, err_frame;
    logic [8:0] wr_addr;
    logic [7:0] wr_data, cmd_byte;
    logic [1:0] disp_mode, tc;
    logic [6:0] vop;
    logic [2:0] bias;

    pcd8544_spi_rx #(.COLS(c_COLS), .ROWS(c_ROWS), .SYNC_STAGES(2)) dut (
        .clock(clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .sce(sce),
        .dc(dc), .lcd_rst(lcd_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .disp_mode(disp_mode), .pwr_down(pwr_down), .vaddr(vaddr),
        .frame_done(frame_done), .err_frame(err_frame), .vop(vop),
        .bias(bias), .tc(tc)
    );

    always #10 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Pulse counters observed away from the active edge.
    int mon_wr = 0, mon_cmd = 0, mon_fd = 0, mon_fd_wr = 0, mon_err = 0;
    always @(negedge clock) begin
        if (wr_en)              mon_wr++;
        if (cmd_valid)          mon_cmd++;
        if (frame_done)         mon_fd++;
        if (frame_done && wr_en) mon_fd_wr++;
        if (err_frame)          mon_err++;
    end

    // Reference model state.
    int mx, my, mh, mv, mpd, mdisp, mvop, mbias, mtc, mcmdb;
    int exp_addr, exp_data;
    int exp_wr = 0, exp_cmd = 0, exp_fd = 0, exp_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mh = 0; mv = 0; mpd = 1; mdisp = 0;
        mvop = 0; mbias = 0; mtc = 0; mcmdb = 0; exp_addr = 0; exp_data = 0;
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        int lin;
        if (d) begin
            exp_wr++;
            exp_addr = my * c_COLS + mx;
            exp_data = int'(b);
            // Walk the frame as a linear index in the active scan order.
            if (mv == 0) begin
                lin = (my * c_COLS + mx + 1) % (c_COLS * c_ROWS);
                mx = lin % c_COLS; my = lin / c_COLS;
            end else begin
                lin = (mx * c_ROWS + my + 1) % (c_COLS * c_ROWS);
                mx = lin / c_ROWS; my = lin % c_ROWS;
            end
            if (lin == 0) exp_fd++;
        end else begin
            exp_cmd++;
            mcmdb = int'(b);
            if (b >= 8'h20 && b <= 8'h27) begin
                mpd = int'(b[2]); mv = int'(b[1]); mh = int'(b[0]);
            end else if (mh == 0) begin
                if (b >= 8'h08 && b <= 8'h0F)
                    mdisp = int'({b[2], b[0]});
                else if (b >= 8'h40 && b <= 8'h47) begin
                    if (int'(b) - 'h40 < c_ROWS) my = int'(b) - 'h40;
                end else if (b >= 8'h80) begin
                    if (int'(b) - 'h80 < c_COLS) mx = int'(b) - 'h80;
                end
            end else begin
`ifdef RX_VOP_EN
                if (b >= 8'h04 && b <= 8'h07)      mtc   = int'(b) - 4;
                else if (b >= 8'h10 && b <= 8'h17) mbias = int'(b) - 'h10;
                else if (b >= 8'h80)               mvop  = int'(b) - 'h80;
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("wr_count", mon_wr, exp_wr);
        chk("wr_addr", int'(wr_addr), exp_addr);
        chk("wr_data", int'(wr_data), exp_data);
        chk("frame_done", mon_fd, exp_fd);
        chk("frame_done_with_wr", mon_fd_wr, exp_fd);
        chk("cmd_count", mon_cmd, exp_cmd);
        chk("cmd_byte", int'(cmd_byte), mcmdb);
        chk("disp_mode", int'(disp_mode), mdisp);
        chk("pwr_down", int'(pwr_down), mpd);
        chk("vaddr", int'(vaddr), mv);
        chk("err_frame", mon_err, exp_err);
        chk("vop", int'(vop), mvop);
        chk("bias", int'(bias), mbias);
        chk("tc", int'(tc), mtc);
    endtask

    // Clock n bits MSB first with a 4-clock sclk period; leaves sclk low.
    task automatic shift_bits(input int n, input logic [7:0] v, input logic d);
        sce = 1'b0;
        dc  = d;
        for (int i = 0; i < n; i++) begin
            mosi = v[7-i];
            sclk = 1'b0;
            repeat (2) @(negedge clock);
            sclk = 1'b1;
            repeat (2) @(negedge clock);
        end
        sclk = 1'b0;
    endtask

    task automatic send(input logic d, input logic [7:0] b, input logic keep_low);
        shift_bits(8, b, d);
        if (!keep_low) sce = 1'b1;
        repeat (6) @(negedge clock);
        model_byte(d, b);
        check_all();
    endtask

    logic [7:0] r_val;

    initial begin
        Reset = 1'b0; lcd_rst = 1'b1; sce = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
        repeat (3) @(negedge clock);
        Reset = 1'b1;
        repeat (6) @(negedge clock);
        model_reset();
        check_all();

        // Extended-set configuration, then back to basic set.
        send(1'b0, 8'h21, 1'b0);
        send(1'b0, 8'hB1, 1'b1);
        send(1'b0, 8'h04, 1'b1);
        send(1'b0, 8'h14, 1'b0);
        send(1'b0, 8'h20, 1'b0);
        send(1'b0, 8'h0C, 1'b0);

        // Last cell of the frame wraps to (0,0).
        send(1'b0, 8'h45, 1'b0);
        send(1'b0, 8'hD3, 1'b0);
        send(1'b1, 8'hAA, 1'b0);
        chk("last_cell_addr", int'(wr_addr), 503);
        send(1'b1, 8'h55, 1'b0);
        chk("wrapped_addr", int'(wr_addr), 0);

        // Vertical addressing walks down the banks.
        send(1'b0, 8'h22, 1'b0);
        send(1'b0, 8'h80, 1'b1);
        send(1'b0, 8'h40, 1'b0);
        for (int i = 0; i < 7; i++) send(1'b1, 8'(i + 1), 1'b1);
        chk("vert_col1", int'(wr_addr), 1);

        // Partial byte aborted by deselect, then a clean data byte.
        shift_bits(5, 8'hFF, 1'b1);
        sce = 1'b1;
        repeat (6) @(negedge clock);
        exp_err++;
        send(1'b1, 8'h3C, 1'b0);

        // Out-of-range pointer commands are ignored.
        send(1'b0, 8'h20, 1'b0);
        send(1'b0, 8'h46, 1'b0);
        send(1'b0, 8'hD4, 1'b0);
        send(1'b0, 8'h43, 1'b0);
        send(1'b0, 8'h85, 1'b0);

        // LCD reset mid-byte discards it without an error pulse.
        shift_bits(4, 8'hA5, 1'b1);
        lcd_rst = 1'b0;
        repeat (3) @(negedge clock);
        shift_bits(4, 8'h50, 1'b1);
        sce = 1'b1;
        repeat (3) @(negedge clock);
        lcd_rst = 1'b1;
        repeat (6) @(negedge clock);
        model_reset();
        check_all();
        send(1'b0, 8'h40, 1'b0);
        send(1'b1, 8'h77, 1'b0);
        chk("post_rst_addr", int'(wr_addr), 0);

        // Randomized traffic, mostly data with occasional aborted bytes.
        for (int n = 0; n < 250; n++) begin
            r_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                shift_bits($urandom_range(1, 7), r_val, 1'b1);
                sce = 1'b1;
                repeat (6) @(negedge clock);
                exp_err++;
                chk("err_frame_rand", mon_err, exp_err);
            end else begin
                send(($urandom_range(0, 2) != 0), r_val, 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
